// File: rtl/game_score_fsm.sv
// Point-by-point game scorer: tracks both players' scores and derives regular
// play, overtime/deuce, advantage and win, with an optional sudden-death cap.
module game_score_fsm #(
  parameter int WIN_SCORE    = 13,
  parameter int SCORE_W      = 6,
  parameter int SUDDEN_DEATH = 0,
  parameter int DC_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic               p1_point,
  input  logic               p2_point,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [2:0]         state,
  output logic [DC_W-1:0]    deuce_count,
  output logic               sudden_death,
  output logic               game_over,
  output logic               win_pulse,
  output logic               conflict
);

  typedef enum logic [2:0] {
    REGULAR  = 3'b000,
    OVERTIME = 3'b001,
    P1_ADV   = 3'b010,
    P2_ADV   = 3'b011,
    P1_WIN   = 3'b100,
    P2_WIN   = 3'b101
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [DC_W-1:0]    DC_MAX    = {DC_W{1'b1}};
  localparam logic [SCORE_W:0]   WIN_V     = (SCORE_W+1)'(WIN_SCORE);
  localparam logic [SCORE_W:0]   TIE_V     = (SCORE_W+1)'(WIN_SCORE - 1);
  localparam logic [DC_W:0]      CAP_V     = (DC_W+1)'(SUDDEN_DEATH);
  localparam logic               SD_EN     = (SUDDEN_DEATH != 0);

  state_t             cur_state, nxt_state;
  logic [SCORE_W-1:0] p1_nxt, p2_nxt;
  logic [DC_W-1:0]    dc_nxt;
  logic               conflict_nxt, win_nxt, over_nxt, sd_nxt;
  logic [SCORE_W:0]   p1_ext, p2_ext;

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [DC_W-1:0] sat_dc(input logic [DC_W-1:0] v);
    return (v == DC_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic cap_reached(input logic [DC_W-1:0] dc);
    return SD_EN && ({1'b0, dc} >= CAP_V);
  endfunction

  function automatic logic is_win(input state_t s);
    return (s == P1_WIN) || (s == P2_WIN);
  endfunction

  // Unsaturated, one-bit-wider scores so the regular-play win test never sees a wrapped value
  assign p1_ext = {1'b0, p1_score} + {{SCORE_W{1'b0}}, p1_point};
  assign p2_ext = {1'b0, p2_score} + {{SCORE_W{1'b0}}, p2_point};

  always_comb begin
    nxt_state    = cur_state;
    p1_nxt       = p1_score;
    p2_nxt       = p2_score;
    dc_nxt       = deuce_count;
    conflict_nxt = 1'b0;
    if (new_game) begin
      nxt_state = REGULAR;
      p1_nxt    = '0;
      p2_nxt    = '0;
      dc_nxt    = '0;
    end else begin
      case (cur_state)
        REGULAR, OVERTIME, P1_ADV, P2_ADV: begin
          if (p1_point && p2_point) begin
            conflict_nxt = 1'b1;
          end else if (p1_point || p2_point) begin
            if (p1_point) p1_nxt = sat_score(p1_score);
            if (p2_point) p2_nxt = sat_score(p2_score);
            if (cur_state == REGULAR) begin
              if (p1_point && (p1_ext == WIN_V))      nxt_state = P1_WIN;
              else if (p2_point && (p2_ext == WIN_V)) nxt_state = P2_WIN;
              else if ((p1_ext == TIE_V) && (p2_ext == TIE_V)) nxt_state = OVERTIME;
            end else if (cur_state == OVERTIME) begin
              if (cap_reached(deuce_count)) nxt_state = p1_point ? P1_WIN : P2_WIN;
              else                          nxt_state = p1_point ? P1_ADV : P2_ADV;
            end else if (cur_state == P1_ADV) begin
              if (p1_point) begin
                nxt_state = P1_WIN;
              end else begin
                nxt_state = OVERTIME;
                dc_nxt    = sat_dc(deuce_count);
              end
            end else begin
              if (p2_point) begin
                nxt_state = P2_WIN;
              end else begin
                nxt_state = OVERTIME;
                dc_nxt    = sat_dc(deuce_count);
              end
            end
          end
        end
        P1_WIN, P2_WIN: ;
        default: nxt_state = REGULAR;
      endcase
    end
    win_nxt  = is_win(nxt_state) && !is_win(cur_state);
    over_nxt = is_win(nxt_state);
    sd_nxt   = (nxt_state == OVERTIME) && cap_reached(dc_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state    <= REGULAR;
      p1_score     <= '0;
      p2_score     <= '0;
      deuce_count  <= '0;
      win_pulse    <= 1'b0;
      game_over    <= 1'b0;
      sudden_death <= 1'b0;
      conflict     <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      p1_score     <= p1_nxt;
      p2_score     <= p2_nxt;
      deuce_count  <= dc_nxt;
      win_pulse    <= win_nxt;
      game_over    <= over_nxt;
      sudden_death <= sd_nxt;
      conflict     <= conflict_nxt;
    end
  end

  assign state = cur_state;

endmodule
